// File: rtl/counter_bus_arbiter_pkg.sv
// Shared definitions for the counter peripheral bus arbiter: default bus
// widths, counter register map and the sequencer state encoding.
package counter_bus_arbiter_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 16;

    localparam logic [DEF_ADDR_W-1:0] REG_TCCR  = 4'd1;
    localparam logic [DEF_ADDR_W-1:0] REG_TCNT  = 4'd2;
    localparam logic [DEF_ADDR_W-1:0] REG_OCR   = 4'd3;
    localparam logic [DEF_ADDR_W-1:0] REG_ICR   = 4'd4;
    localparam logic [DEF_ADDR_W-1:0] REG_TIMSK = 4'd5;
    localparam logic [DEF_ADDR_W-1:0] REG_TCCR2 = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_DONE    = 2'd2,
        ST_RECOVER = 2'd3
    } arb_state_e;

endpackage

// File: rtl/counter_bus_arbiter_if.sv
// Slave-side register bus of the counter peripheral. The arbiter drives the
// command half through the master modport; the register block answers with
// read data and a registered ack through the slave modport.
interface counter_bus_arbiter_if
    import counter_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              o_bus_select;
    logic              o_bus_wr;
    logic [ADDR_W-1:0] o_reg_addr;
    logic [DATA_W-1:0] o_bus_data;
    logic [DATA_W-1:0] i_bus_data;
    logic              i_bus_ack;

    modport master (
        output o_bus_select, o_bus_wr, o_reg_addr, o_bus_data,
        input  i_bus_data, i_bus_ack
    );

    modport slave (
        input  o_bus_select, o_bus_wr, o_reg_addr, o_bus_data,
        output i_bus_data, i_bus_ack
    );
endinterface

// File: rtl/counter_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker. Searches upward from ptr+1 with wrap and
// grants the first requester found; the grant is one-hot, or zero when idle.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);

    // Walk the requesters in priority order starting just after the last owner.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] cand;
        gnt   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_bus_arbiter.sv
// Round-robin arbiter and sequencer sharing the counter register bus between
// NREQ requesters. One transaction at a time: select is held until ack, read
// data is returned with a one-cycle done pulse, then the bus must see ack low
// before the next select.
// Optional feature: define ARB_TIMEOUT_EN to abort an ACCESS after TMO_CYC
// cycles without ack (o_err=1, o_rdata=0); otherwise ACCESS waits forever.
module counter_bus_arbiter
    import counter_bus_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TMO_CYC = 255
) (
    input  logic                     i_sysclk,
    input  logic                     i_sysrst_n,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ-1:0]          i_wr,
    input  logic [NREQ*ADDR_W-1:0]   i_addr,
    input  logic [NREQ*DATA_W-1:0]   i_wdata,
    output logic [NREQ-1:0]          o_gnt,
    output logic [NREQ-1:0]          o_done,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_err,
    counter_bus_arbiter_if.master    bus
);

    localparam int PTR_W = $clog2(NREQ);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] owner_q;
    logic [NREQ-1:0]  pick_gnt;
    logic [PTR_W-1:0] pick_idx;
    logic             launch;
    logic             finish;
    logic             timed_out;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req (i_req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt)
    );

    // Turn the one-hot pick into an index for selecting the winner's command.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) pick_idx = PTR_W'(i);
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    // Age of the current ACCESS; restarts whenever a new transaction launches.
    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n)                tmo_cnt_q <= '0;
        else if (launch)                tmo_cnt_q <= '0;
        else if (state_q == ST_ACCESS)  tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
`endif

    // Next-state logic; RECOVER with ack already low arbitrates directly so a
    // waiting requester is not delayed by an extra IDLE cycle.
    always_comb begin
        state_d   = state_q;
        launch    = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    launch  = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (bus.i_bus_ack) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    state_d   = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (!bus.i_bus_ack) begin
                    if (|i_req) begin
                        launch  = 1'b1;
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    // Bus command latch, grant/done outputs, read data capture and rr pointer.
    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            o_gnt            <= '0;
            o_done           <= '0;
            o_rdata          <= '0;
            rr_ptr_q         <= PTR_W'(NREQ - 1);
            owner_q          <= '0;
            bus.o_bus_select <= 1'b0;
            bus.o_bus_wr     <= 1'b0;
            bus.o_reg_addr   <= '0;
            bus.o_bus_data   <= '0;
        end else begin
            if (state_q == ST_DONE) o_done <= '0;
            if (launch) begin
                o_gnt            <= pick_gnt;
                owner_q          <= pick_idx;
                bus.o_bus_select <= 1'b1;
                bus.o_bus_wr     <= i_wr[pick_idx];
                bus.o_reg_addr   <= i_addr[pick_idx*ADDR_W +: ADDR_W];
                bus.o_bus_data   <= i_wdata[pick_idx*DATA_W +: DATA_W];
            end
            if (finish) begin
                bus.o_bus_select <= 1'b0;
                o_gnt            <= '0;
                o_done           <= o_gnt;
                rr_ptr_q         <= owner_q;
                if (timed_out)         o_rdata <= '0;
                else if (!bus.o_bus_wr) o_rdata <= bus.i_bus_data;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Error flag accompanies the done pulse of a timed-out transaction only.
    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n)             o_err <= 1'b0;
        else if (finish)             o_err <= timed_out;
        else if (state_q == ST_DONE) o_err <= 1'b0;
    end
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_counter_bus_arbiter.sv
// Bench for counter_bus_arbiter: directed requester scenarios against a
// one-cycle registered slave, a transaction-level reference model checked
// every cycle, and literal expectations for the key timing points.
module tb_counter_bus_arbiter;
    import counter_bus_arbiter_pkg::*;

    localparam int NREQ    = 2;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 16;
    localparam int TMO_CYC = 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        i_req = '0;
    logic [NREQ-1:0]        i_wr = '0;
    logic [NREQ*ADDR_W-1:0] i_addr = '0;
    logic [NREQ*DATA_W-1:0] i_wdata = '0;
    logic [NREQ-1:0]        o_gnt;
    logic [NREQ-1:0]        o_done;
    logic [DATA_W-1:0]      o_rdata;
    logic                   o_err;
    logic [DATA_W-1:0]      slave_rdata = '0;
    logic                   slave_mute = 1'b0;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int sel_cnt = 0;
    int done_cnt [NREQ];
    logic [NREQ-1:0] hold_mask = '0;
    logic [NREQ-1:0] last_gnt_seen = '0;
    logic [NREQ-1:0] gnt_log [$];

    counter_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    counter_bus_arbiter #(
        .NREQ    (NREQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .i_sysclk   (clk),
        .i_sysrst_n (rst_n),
        .i_req      (i_req),
        .i_wr       (i_wr),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_gnt      (o_gnt),
        .o_done     (o_done),
        .o_rdata    (o_rdata),
        .o_err      (o_err),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    // Slave: ack registered one cycle after select, drops one cycle after deselect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus_if.i_bus_ack <= 1'b0;
        else        bus_if.i_bus_ack <= bus_if.o_bus_select & ~slave_mute;
    end
    assign bus_if.i_bus_data = slave_rdata;

    // Reference model state: what the arbiter must present during the next cycle.
    bit                m_busy, m_block;
    int                m_owner, m_last, m_age;
    logic [NREQ-1:0]   m_gnt, m_done;
    logic              m_sel, m_wr, m_err;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;

    // Transaction-level model: a committed transaction ends on ack (or timeout),
    // the done cycle blocks arbitration, and a new winner needs ack low.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 0; m_block = 0; m_owner = 0; m_last = NREQ - 1; m_age = 0;
            m_gnt = '0; m_done = '0; m_sel = 0; m_wr = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            bit tmo_hit;
            m_done  = '0;
            m_err   = 1'b0;
            tmo_hit = 0;
            if (m_busy) begin
                m_age++;
`ifdef ARB_TIMEOUT_EN
                tmo_hit = !bus_if.i_bus_ack && (m_age == TMO_CYC);
`endif
                if (bus_if.i_bus_ack || tmo_hit) begin
                    m_busy  = 0;
                    m_block = 1;
                    m_sel   = 0;
                    m_done  = m_gnt;
                    m_gnt   = '0;
                    m_last  = m_owner;
                    if (tmo_hit) begin
                        m_err   = 1'b1;
                        m_rdata = '0;
                    end else if (!m_wr) begin
                        m_rdata = bus_if.i_bus_data;
                    end
                end
            end else if (m_block) begin
                m_block = 0;
            end else if (!bus_if.i_bus_ack && i_req != '0) begin
                for (int i = 1; i <= NREQ; i++) begin
                    int c;
                    c = (m_last + i) % NREQ;
                    if (i_req[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_gnt   = '0;
                m_gnt[m_owner] = 1'b1;
                m_sel   = 1;
                m_busy  = 1;
                m_age   = 0;
                m_wr    = i_wr[m_owner];
                m_addr  = i_addr[m_owner*ADDR_W +: ADDR_W];
                m_wdata = i_wdata[m_owner*DATA_W +: DATA_W];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: actual=%0h expected=%0h cycle=%0d",
                      name, actual, expected, cyc);
    endtask

    // Per-cycle comparison against the model, plus the ack-low gap rule.
    initial begin
        logic prev_sel, prev_ack;
        prev_sel = 0;
        prev_ack = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("gnt", 32'(o_gnt), 32'(m_gnt));
                checkOutput("done", 32'(o_done), 32'(m_done));
                checkOutput("select", 32'(bus_if.o_bus_select), 32'(m_sel));
                if (m_sel) begin
                    checkOutput("bus_wr", 32'(bus_if.o_bus_wr), 32'(m_wr));
                    checkOutput("reg_addr", 32'(bus_if.o_reg_addr), 32'(m_addr));
                    checkOutput("bus_data", 32'(bus_if.o_bus_data), 32'(m_wdata));
                end
                if (m_done != '0) begin
                    checkOutput("rdata", 32'(o_rdata), 32'(m_rdata));
                    checkOutput("err", 32'(o_err), 32'(m_err));
                end
                if (bus_if.o_bus_select && !prev_sel)
                    checkOutput("ack_gap", 32'(prev_ack), 32'd0);
                prev_sel = bus_if.o_bus_select;
                prev_ack = bus_if.i_bus_ack;
            end else begin
                prev_sel = 0;
                prev_ack = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [NREQ-1:0] wr,
                                 input logic [NREQ*ADDR_W-1:0] addr,
                                 input logic [NREQ*DATA_W-1:0] wdata,
                                 input logic [NREQ-1:0] hold);
        i_req     = req;
        i_wr      = wr;
        i_addr    = addr;
        i_wdata   = wdata;
        hold_mask = hold;
    endtask

    // Advance one cycle; requesters not told to hold drop their request on done.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus_if.o_bus_select) sel_cnt++;
        for (int k = 0; k < NREQ; k++) begin
            if (o_done[k]) begin
                done_cnt[k]++;
                if (!hold_mask[k]) i_req[k] = 1'b0;
            end
        end
        if (o_gnt != '0 && o_gnt != last_gnt_seen) gnt_log.push_back(o_gnt);
        last_gnt_seen = o_gnt;
    endtask

    task automatic clearCounts();
        sel_cnt = 0;
        for (int k = 0; k < NREQ; k++) done_cnt[k] = 0;
        gnt_log.delete();
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int t0, fs, ls, dc;
        logic [DATA_W-1:0] rd;
        logic              er;

        $display("[TB] start");
        clearCounts();
        #2;
        checkOutput("rst_gnt", 32'(o_gnt), 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        checkOutput("rst_select", 32'(bus_if.o_bus_select), 32'd0);
        checkOutput("rst_rdata", 32'(o_rdata), 32'd0);
        checkOutput("rst_err", 32'(o_err), 32'd0);
        resetDut();
        repeat (2) tick();

        // Single read from requester 0.
        $display("[TB] single read");
        slave_rdata = 16'h1234;
        applyStimulus(2'b01, 2'b00, {4'd0, REG_TCNT}, '0, 2'b00);
        t0 = cyc; fs = -1; ls = -1; dc = -1; rd = '0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (bus_if.o_bus_select) begin
                if (fs < 0) fs = cyc - t0;
                ls = cyc - t0;
            end
            if (o_done[0]) begin
                dc = cyc - t0;
                rd = o_rdata;
            end
        end
        checkOutput("t1_first_select", 32'(fs), 32'd1);
        checkOutput("t1_last_select", 32'(ls), 32'd2);
        checkOutput("t1_done_cycle", 32'(dc), 32'd3);
        checkOutput("t1_rdata", 32'(rd), 32'h1234);

        // Write from requester 1; read data must not change.
        $display("[TB] write");
        clearCounts();
        slave_rdata = 16'hDEAD;
        applyStimulus(2'b10, 2'b10, {REG_OCR, 4'd0}, {16'hBEEF, 16'h0000}, 2'b00);
        for (int n = 0; n < 10; n++) begin
            tick();
            if (bus_if.o_bus_select) begin
                checkOutput("t2_wr", 32'(bus_if.o_bus_wr), 32'd1);
                checkOutput("t2_addr", 32'(bus_if.o_reg_addr), 32'd3);
                checkOutput("t2_data", 32'(bus_if.o_bus_data), 32'hBEEF);
            end
        end
        checkOutput("t2_done1_count", 32'(done_cnt[1]), 32'd1);
        checkOutput("t2_done0_count", 32'(done_cnt[0]), 32'd0);
        checkOutput("t2_rdata_kept", 32'(o_rdata), 32'h1234);

        // Contention after reset: grants alternate starting with requester 0.
        $display("[TB] contention");
        resetDut();
        clearCounts();
        slave_rdata = 16'h0A0A;
        applyStimulus(2'b11, 2'b01, {REG_ICR, REG_TCCR}, {16'h0, 16'h5555}, 2'b11);
        repeat (20) tick();
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b00);
        repeat (8) tick();
        checkOutput("t3_grant_count_ok", 32'(gnt_log.size() >= 4), 32'd1);
        if (gnt_log.size() >= 4) begin
            checkOutput("t3_grant0", 32'(gnt_log[0]), 32'd1);
            checkOutput("t3_grant1", 32'(gnt_log[1]), 32'd2);
            checkOutput("t3_grant2", 32'(gnt_log[2]), 32'd1);
            checkOutput("t3_grant3", 32'(gnt_log[3]), 32'd2);
        end

        // Withdraw during ACCESS: the transaction still completes exactly once.
        $display("[TB] withdraw");
        clearCounts();
        slave_rdata = 16'h7777;
        applyStimulus(2'b01, 2'b00, {4'd0, REG_TIMSK}, '0, 2'b00);
        tick();
        i_req[0] = 1'b0;
        repeat (10) tick();
        checkOutput("t4_done0_count", 32'(done_cnt[0]), 32'd1);
        checkOutput("t4_select_cycles", 32'(sel_cnt), 32'd2);
        checkOutput("t4_rdata", 32'(o_rdata), 32'h7777);

        // Reset in the middle of an access.
        $display("[TB] reset mid-op");
        applyStimulus(2'b10, 2'b00, {REG_TCCR2, 4'd0}, '0, 2'b00);
        tick();
        checkOutput("t5_select_before", 32'(bus_if.o_bus_select), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_select_async", 32'(bus_if.o_bus_select), 32'd0);
        checkOutput("t5_gnt_async", 32'(o_gnt), 32'd0);
        checkOutput("t5_done_async", 32'(o_done), 32'd0);
        applyStimulus(2'b00, 2'b00, '0, '0, 2'b00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("t5_idle_gnt", 32'(o_gnt), 32'd0);
        checkOutput("t5_idle_select", 32'(bus_if.o_bus_select), 32'd0);
        applyStimulus(2'b11, 2'b00, {REG_OCR, REG_TCNT}, '0, 2'b00);
        tick();
        checkOutput("t5_first_winner", 32'(o_gnt), 32'd1);
        repeat (12) tick();

`ifdef ARB_TIMEOUT_EN
        // Ack never arrives: timeout after TMO_CYC access cycles, then normal service.
        $display("[TB] timeout");
        slave_mute = 1'b1;
        applyStimulus(2'b01, 2'b00, {4'd0, REG_TCNT}, '0, 2'b00);
        t0 = cyc; dc = -1; rd = 16'hFFFF; er = 1'b0;
        for (int n = 0; n < 16; n++) begin
            tick();
            if (o_done[0]) begin
                dc = cyc - t0;
                rd = o_rdata;
                er = o_err;
            end
        end
        checkOutput("t6_done_cycle", 32'(dc), 32'(TMO_CYC + 1));
        checkOutput("t6_err", 32'(er), 32'd1);
        checkOutput("t6_rdata", 32'(rd), 32'd0);
        slave_mute  = 1'b0;
        slave_rdata = 16'h0F0F;
        applyStimulus(2'b10, 2'b00, {REG_TCNT, 4'd0}, '0, 2'b00);
        er = 1'b1; rd = '0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (o_done[1]) begin
                rd = o_rdata;
                er = o_err;
            end
        end
        checkOutput("t6_next_rdata", 32'(rd), 32'h0F0F);
        checkOutput("t6_next_err", 32'(er), 32'd0);
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
